hh_gate_array: RTL and testbench

HH_GATE_ARRAY -- requirements
Module: hh_gate_array

---
 rtl/hh_gate_array.sv | 161 ++++++++++++++++
 tb/tb_hh_gate_array.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hh_gate_array.sv
// Hodgkin-Huxley gating-variable array: one Euler step per start, channels updated in turn.
// Define HH_GATE_CLAMP_EN to saturate each updated state to [0, SCALE]; otherwise it wraps to WIDTH bits.
module hh_gate_array #(
  parameter int WIDTH = 16,
  parameter int NCH = 3,
  parameter int DEPTH = 32,
  parameter int SCALE = 1000,
  parameter int VMIN = -100,
  parameter int VSHIFT = 3,
  parameter logic [NCH*WIDTH-1:0] INIT_VEC = {16'd318, 16'd600, 16'd53},
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  V,
  input  logic [WIDTH-1:0]         dt,
  output logic                     busy,
  output logic                     done,
  output logic [NCH*WIDTH-1:0]     x_out,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [CW-1:0]            wr_ch,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_err
);
  localparam int PW = 3*WIDTH + 2;
  localparam logic signed [PW-1:0] SCALE_P = PW'(SCALE);
  localparam logic signed [PW-1:0] SCALE_SQ = SCALE_P * SCALE_P;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WB, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic signed [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0]        dt_q, dt_d;
  logic [WIDTH-1:0]        wb_q, wb_d;
  logic [NCH*WIDTH-1:0]    x_q, x_d;
  logic                    wr_err_q, wr_err_d;

  logic [AW-1:0]           idx;
  int                      vd;
  logic                    tbl_we;
  logic [NCH*WIDTH-1:0]    alpha_rd_all, beta_rd_all;

  // Rate-table index is derived from the V latched at start, so it is stable for the whole step.
  always_comb begin
    vd = (int'(v_q) - VMIN) >>> VSHIFT;
    if (vd < 0) idx = '0;
    else if (vd > DEPTH - 1) idx = AW'(DEPTH - 1);
    else idx = AW'(vd);
  end

  assign busy   = (state_q == S_READ) || (state_q == S_CALC) || (state_q == S_WB);
  assign done   = (state_q == S_DONE);
  assign tbl_we = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign wr_err_d = wr_en && busy;
  assign x_out  = x_q;
  assign wr_err = wr_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] a_mem [DEPTH];
      logic [WIDTH-1:0] b_mem [DEPTH];
      logic [WIDTH-1:0] a_rd_q, b_rd_q;
      logic             we;

      assign we = tbl_we && (int'(wr_ch) == gi) && (int'(wr_addr) < DEPTH);

      always_ff @(posedge clk) begin
        if (we && !wr_sel) a_mem[wr_addr] <= wr_data;
        if (we && wr_sel)  b_mem[wr_addr] <= wr_data;
        if (state_q == S_READ) begin
          a_rd_q <= a_mem[idx];
          b_rd_q <= b_mem[idx];
        end
      end

      assign alpha_rd_all[gi*WIDTH +: WIDTH] = a_rd_q;
      assign beta_rd_all[gi*WIDTH +: WIDTH]  = b_rd_q;
    end
  endgenerate

  logic [WIDTH-1:0]        x_cur;
  logic signed [PW-1:0]    x_s, a_s, b_s, dt_s, num_s;
`ifdef HH_GATE_CLAMP_EN
  logic signed [PW-1:0]    sum_s;
`endif

  always_comb begin
    x_cur = x_q[int'(ch_q)*WIDTH +: WIDTH];
    x_s   = PW'(signed'(x_cur));
    a_s   = signed'(PW'(alpha_rd_all[int'(ch_q)*WIDTH +: WIDTH]));
    b_s   = signed'(PW'(beta_rd_all[int'(ch_q)*WIDTH +: WIDTH]));
    dt_s  = signed'(PW'(dt_q));
    num_s = (a_s * (SCALE_P - x_s) - b_s * x_s) * dt_s;
`ifdef HH_GATE_CLAMP_EN
    sum_s = x_s + num_s / SCALE_SQ;
    if (sum_s < 0) wb_d = '0;
    else if (sum_s > SCALE_P) wb_d = WIDTH'(SCALE);
    else wb_d = sum_s[WIDTH-1:0];
`else
    wb_d = WIDTH'(x_s + num_s / SCALE_SQ);
`endif
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    v_d     = v_q;
    dt_d    = dt_q;
    x_d     = x_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_READ;
          ch_d    = '0;
          v_d     = V;
          dt_d    = dt;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: state_d = S_CALC;
      S_CALC: state_d = S_WB;
      S_WB: begin
        x_d[int'(ch_q)*WIDTH +: WIDTH] = wb_q;
        if (ch_q == CW'(NCH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      v_q      <= '0;
      dt_q     <= '0;
      wb_q     <= '0;
      x_q      <= INIT_VEC;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      v_q      <= v_d;
      dt_q     <= dt_d;
      wb_q     <= (state_q == S_CALC) ? wb_d : wb_q;
      x_q      <= x_d;
      wr_err_q <= wr_err_d;
    end
  end
endmodule

// File: tb/tb_hh_gate_array.sv
// Bench for hh_gate_array: directed vector table, cycle-exact corner sequences, randomized model check.
module tb_hh_gate_array;
  localparam int WIDTH = 16;
  localparam int NCH = 3;
  localparam int DEPTH = 32;
  localparam int SCALE = 1000;
  localparam logic [NCH*WIDTH-1:0] INIT = {16'd318, 16'd600, 16'd600};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic signed [WIDTH-1:0] V = '0;
  logic [WIDTH-1:0] dt = '0;
  logic busy, done, wr_err;
  logic [NCH*WIDTH-1:0] x_out;
  logic wr_en = 1'b0;
  logic wr_sel = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [4:0] wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;

  hh_gate_array #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .SCALE(SCALE), .INIT_VEC(INIT)) dut (
    .clk(clk), .reset(reset), .start(start), .V(V), .dt(dt), .busy(busy), .done(done),
    .x_out(x_out), .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint alpha_m [NCH][DEPTH];
  longint beta_m [NCH][DEPTH];
  longint x_m [NCH];

  typedef struct {
    int ch; int alpha; int beta; int v; int dt; int exp_plain; int exp_clamp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_idx(input int v);
    int d;
    d = v + 100;
    if (d < 0) return 0;
    d = d / 8;
    if (d > DEPTH - 1) return DEPTH - 1;
    return d;
  endfunction

  function automatic longint model_next(input longint x, input longint a, input longint b, input longint t);
    longint r;
    r = x + ((a * (SCALE - x) - b * x) * t) / (longint'(SCALE) * SCALE);
`ifdef HH_GATE_CLAMP_EN
    if (r < 0) r = 0;
    if (r > SCALE) r = SCALE;
`else
    r = r & 64'hFFFF;
    if (r >= 32768) r = r - 65536;
`endif
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) x_m[c] = longint'($signed(INIT[c*WIDTH +: WIDTH]));
  endtask

  task automatic wr(input int sel, input int ch, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel[0]; wr_ch = ch[1:0]; wr_addr = addr[4:0]; wr_data = data[15:0];
    tick();
    wr_en = 1'b0;
    if (sel == 0) alpha_m[ch][addr] = data; else beta_m[ch][addr] = data;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: done timeout, got done=%0b, expected 1 within 40 cycles", name, done);
    end
  endtask

  // Starts a step, waits for done (staying in the done cycle), and advances the model.
  task automatic run_step(input string name, input int v, input int t);
    int ix;
    V = WIDTH'(v); dt = WIDTH'(t); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name);
    ix = model_idx(v);
    for (int c = 0; c < NCH; c++) x_m[c] = model_next(x_m[c], alpha_m[c][ix], beta_m[c][ix], t);
  endtask

  initial begin
    vecs[0] = '{0, 100,   0,  -65, 1000, 640, 640};
    vecs[1] = '{1,   0, 100,  -65, 1000, 540, 540};
    vecs[2] = '{0, 10000, 0,  -65, 1000, 4600, 1000};
    vecs[3] = '{0, 200,   0, -200, 1000, 680, 680};
    vecs[4] = '{0, 300,   0,  300, 1000, 720, 720};
    vecs[5] = '{2,  50,  50,    0,  500, 327, 327};
    vecs[6] = '{1,   0,   7,  -65,  333, 599, 599};

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_x", x_out, INIT);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wr_err", wr_err, 0);
    do_reset();

    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++) begin
        wr(0, c, a, 0);
        wr(1, c, a, 0);
      end

    for (int i = 0; i < 7; i++) begin
      int ix;
      int expx;
      do_reset();
      ix = model_idx(vecs[i].v);
      for (int c = 0; c < NCH; c++) begin
        wr(0, c, ix, (c == vecs[i].ch) ? vecs[i].alpha : 0);
        wr(1, c, ix, (c == vecs[i].ch) ? vecs[i].beta : 0);
      end
      run_step($sformatf("vec%0d", i), vecs[i].v, vecs[i].dt);
`ifdef HH_GATE_CLAMP_EN
      expx = vecs[i].exp_clamp;
`else
      expx = vecs[i].exp_plain;
`endif
      for (int c = 0; c < NCH; c++) begin
        if (c == vecs[i].ch)
          check($sformatf("vec%0d_x%0d", i, c), $signed(x_out[c*WIDTH +: WIDTH]), expx);
        else
          check($sformatf("vec%0d_x%0d", i, c), $signed(x_out[c*WIDTH +: WIDTH]), $signed(INIT[c*WIDTH +: WIDTH]));
      end
      $display("vec %0d ch=%0d V=%0d dt=%0d x=%0d", i, vecs[i].ch, vecs[i].v, vecs[i].dt,
               $signed(x_out[vecs[i].ch*WIDTH +: WIDTH]));
      tick();
    end

    // Handshake timing, ignored start while busy, dropped write with wr_err.
    do_reset();
    wr(0, 0, 4, 100);
    V = -16'sd65; dt = 16'd1000; start = 1'b1;
    check("t27_idle_busy", busy, 0);
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      check($sformatf("t27_busy_c%0d", cyc), busy, (cyc <= 9) ? 1 : 0);
      check($sformatf("t27_done_c%0d", cyc), done, (cyc == 10) ? 1 : 0);
      check($sformatf("t27_wr_err_c%0d", cyc), wr_err, (cyc == 6) ? 1 : 0);
      if (cyc == 10) check("t27_x0", $signed(x_out[15:0]), 640);
      start = (cyc == 4);
      if (cyc == 4) V = 16'sd300;
      wr_en = (cyc == 5); wr_sel = 1'b0; wr_ch = 2'd0; wr_addr = 5'd4; wr_data = 16'd9999;
      tick();
    end
    start = 1'b0; wr_en = 1'b0;
    run_step("t27_after", -65, 1000);
    check("t27_table_kept_x0", $signed(x_out[15:0]), 676);
    $display("seq timing x0=%0d", $signed(x_out[15:0]));
    tick();

    // Simultaneous start and table write in IDLE.
    do_reset();
    wr(0, 0, 4, 0);
    V = -16'sd65; dt = 16'd1000; start = 1'b1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_ch = 2'd0; wr_addr = 5'd4; wr_data = 16'd100;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_done("t17");
    check("t17_x0", $signed(x_out[15:0]), 640);
    $display("seq start+write x0=%0d", $signed(x_out[15:0]));
    tick();

    // Reset in the middle of a step.
    do_reset();
    V = -16'sd65; dt = 16'd1000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 5; cyc++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t28_x", x_out, INIT);
    check("t28_busy", busy, 0);
    check("t28_done", done, 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (done || busy) seen = 1;
      end
      check("t28_no_done_after", seen, 0);
    end
    $display("seq mid-step reset x=%h", x_out);

    // Randomized steps against the arithmetic model.
    do_reset();
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++) begin
        wr(0, c, a, int'($urandom_range(1000)));
        wr(1, c, a, int'($urandom_range(1000)));
      end
    for (int s = 0; s < 30; s++) begin
      int rv;
      int rt;
      if ($urandom_range(2) == 0)
        wr(int'($urandom_range(1)), int'($urandom_range(NCH - 1)), int'($urandom_range(DEPTH - 1)),
           int'($urandom_range(1000)));
      rv = int'($urandom_range(600)) - 250;
      rt = int'($urandom_range(1000));
      run_step($sformatf("rnd%0d", s), rv, rt);
      for (int c = 0; c < NCH; c++)
        check($sformatf("rnd%0d_x%0d", s, c), $signed(x_out[c*WIDTH +: WIDTH]), x_m[c]);
      $display("rnd %0d V=%0d dt=%0d x=%0d,%0d,%0d", s, rv, rt, $signed(x_out[15:0]),
               $signed(x_out[31:16]), $signed(x_out[47:32]));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
